// File: rtl/spi_byte_seq.sv
// Byte sequencer between a register interface and spi_ctrl: TX FIFO with per-byte DC/last flags.
// Optional per-entry repeat count enabled by defining SPI_SEQ_REPEAT_EN.
module spi_byte_seq #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          wr_valid,
    input  logic [7:0]    wr_data,
    input  logic          wr_dc,
    input  logic          wr_last,
    input  logic [7:0]    wr_rep,
    output logic          wr_ready,
    input  logic          flush,
    output logic [7:0]    rd_data,
    output logic          rd_valid,
    output logic          idle,
    output logic [AW:0]   level,
    output logic          spi_start,
    output logic [7:0]    spi_data_in,
    output logic          spi_dc_in,
    output logic          spi_end_txn,
    input  logic          spi_busy,
    input  logic [7:0]    spi_data_out
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT
    } state_e;

    localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

    logic [7:0] mem_data [DEPTH];
    logic       mem_dc   [DEPTH];
    logic       mem_last [DEPTH];

`ifdef SPI_SEQ_REPEAT_EN
    logic [7:0] mem_rep  [DEPTH];
    logic [7:0] rep_q, rep_d;
    logic       last_q, last_d;
`else
    logic       unused_rep;
    assign unused_rep = ^wr_rep;
`endif

    state_e      state_q, state_d;
    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [AW:0] level_q, level_d;
    logic        start_q, start_d;
    logic [7:0]  sdata_q, sdata_d;
    logic        sdc_q, sdc_d;
    logic        send_q, send_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        rvalid_q, rvalid_d;
    logic        push, pop;

    assign wr_ready    = (level_q != LVL_FULL);
    assign push        = wr_valid && wr_ready;
    assign level       = level_q;
    assign idle        = (level_q == '0) && (state_q == S_IDLE) && !spi_busy;
    assign spi_start   = start_q;
    assign spi_data_in = sdata_q;
    assign spi_dc_in   = sdc_q;
    assign spi_end_txn = send_q;
    assign rd_data     = rdata_q;
    assign rd_valid    = rvalid_q;

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem_data[wptr_q] <= wr_data;
            mem_dc[wptr_q]   <= wr_dc;
            mem_last[wptr_q] <= wr_last;
`ifdef SPI_SEQ_REPEAT_EN
            mem_rep[wptr_q]  <= wr_rep;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        start_d  = start_q;
        sdata_d  = sdata_q;
        sdc_d    = sdc_q;
        send_d   = send_q;
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;
        pop      = 1'b0;
`ifdef SPI_SEQ_REPEAT_EN
        rep_d    = rep_q;
        last_d   = last_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (level_q != '0 && !spi_busy) begin
                    pop     = 1'b1;
                    sdata_d = mem_data[rptr_q];
                    sdc_d   = mem_dc[rptr_q];
                    start_d = 1'b1;
                    state_d = S_ISSUE;
`ifdef SPI_SEQ_REPEAT_EN
                    rep_d   = mem_rep[rptr_q];
                    last_d  = mem_last[rptr_q];
                    // Hold CS across repeats; only the final issue carries the entry's last flag.
                    send_d  = (mem_rep[rptr_q] == 8'd0) ? mem_last[rptr_q] : 1'b0;
`else
                    send_d  = mem_last[rptr_q];
`endif
                end
            end
            S_ISSUE: begin
                start_d = 1'b0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (!spi_busy) begin
                    rdata_d  = spi_data_out;
                    rvalid_d = 1'b1;
                    state_d  = S_IDLE;
`ifdef SPI_SEQ_REPEAT_EN
                    if (rep_q != 8'd0) begin
                        rep_d   = rep_q - 8'd1;
                        start_d = 1'b1;
                        send_d  = (rep_q == 8'd1) ? last_q : 1'b0;
                        state_d = S_ISSUE;
                    end
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase

        rptr_d  = rptr_q + AW'(pop);
        wptr_d  = wptr_q + AW'(push);
        level_d = level_q + (AW+1)'(push) - (AW+1)'(pop);
        if (flush) begin
            rptr_d  = '0;
            wptr_d  = '0;
            level_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= S_IDLE;
            wptr_q   <= '0;
            rptr_q   <= '0;
            level_q  <= '0;
            start_q  <= 1'b0;
            sdata_q  <= '0;
            sdc_q    <= 1'b0;
            send_q   <= 1'b1;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
`ifdef SPI_SEQ_REPEAT_EN
            rep_q    <= '0;
            last_q   <= 1'b1;
`endif
        end else begin
            state_q  <= state_d;
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            level_q  <= level_d;
            start_q  <= start_d;
            sdata_q  <= sdata_d;
            sdc_q    <= sdc_d;
            send_q   <= send_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
`ifdef SPI_SEQ_REPEAT_EN
            rep_q    <= rep_d;
            last_q   <= last_d;
`endif
        end
    end

endmodule

// File: tb/tb_spi_byte_seq.sv
// Self-checking bench for spi_byte_seq: spi_ctrl stand-in plus a queue-based reference model.
module tb_spi_byte_seq;
    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic          clk = 1'b0;
    logic          rstn = 1'b1;
    logic          wr_valid = 1'b0;
    logic [7:0]    wr_data = '0;
    logic          wr_dc = 1'b0;
    logic          wr_last = 1'b0;
    logic [7:0]    wr_rep = '0;
    logic          wr_ready;
    logic          flush = 1'b0;
    logic [7:0]    rd_data;
    logic          rd_valid;
    logic          idle;
    logic [AW:0]   level;
    logic          spi_start;
    logic [7:0]    spi_data_in;
    logic          spi_dc_in;
    logic          spi_end_txn;
    logic          spi_busy;
    logic [7:0]    spi_data_out = '0;

    spi_byte_seq #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rstn(rstn),
        .wr_valid(wr_valid), .wr_data(wr_data), .wr_dc(wr_dc), .wr_last(wr_last),
        .wr_rep(wr_rep), .wr_ready(wr_ready), .flush(flush),
        .rd_data(rd_data), .rd_valid(rd_valid), .idle(idle), .level(level),
        .spi_start(spi_start), .spi_data_in(spi_data_in), .spi_dc_in(spi_dc_in),
        .spi_end_txn(spi_end_txn), .spi_busy(spi_busy), .spi_data_out(spi_data_out)
    );

    always #5 clk = ~clk;

    // spi_ctrl stand-in: busy from the edge that samples start, for a random number of cycles.
    logic       mbusy = 1'b0;
    logic       hold_busy = 1'b0;
    logic       ret_a5 = 1'b0;
    int         mcnt = 0;
    int         dur_min = 1, dur_max = 3;
    logic [7:0] mret = '0;
    logic [7:0] ret;

    assign spi_busy = mbusy | hold_busy;

    always @(posedge clk) begin
        if (spi_start && !mbusy) begin
            mbusy <= 1'b1;
            mcnt  <= $urandom_range(dur_max, dur_min);
        end else if (mbusy) begin
            if (mcnt <= 1) begin
                ret = ret_a5 ? 8'hA5 : 8'($urandom);
                mbusy        <= 1'b0;
                spi_data_out <= ret;
                mret         <= ret;
            end else begin
                mcnt <= mcnt - 1;
            end
        end
    end

    typedef struct packed {
        logic [7:0] d;
        logic       dc;
        logic       last;
        logic [7:0] rep;
    } ent_t;

    ent_t mq[$];
    ent_t cur;
    int   cur_rem = 0;
    logic inflight = 1'b0;
    logic mb1 = 1'b0, mb2 = 1'b0;
    int   n_start = 0, n_rv = 0;
    int   n_checks = 0, n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock: inputs set before the call are sampled on the posedge, outputs checked at the negedge.
    task automatic tick();
        logic wv, fl, exp_rv, eend;
        int   pre;
        ent_t e;
        wv     = wr_valid;
        fl     = flush;
        pre    = mq.size();
        e.d    = wr_data;
        e.dc   = wr_dc;
        e.last = wr_last;
`ifdef SPI_SEQ_REPEAT_EN
        e.rep  = wr_rep;
`else
        e.rep  = 8'd0;
`endif
        @(negedge clk);
        exp_rv = inflight && mb2 && !mb1;
        check("rd_valid", rd_valid, exp_rv);
        if (rd_valid) n_rv++;
        if (exp_rv) begin
            check("rd_data", rd_data, mret);
            inflight = 1'b0;
        end
        if (spi_start) begin
            n_start++;
            if (cur_rem > 0 || mq.size() > 0) begin
                if (cur_rem > 0) begin
                    cur_rem--;
                    eend = (cur_rem == 0) ? cur.last : 1'b0;
                end else begin
                    cur     = mq.pop_front();
                    cur_rem = int'(cur.rep);
                    eend    = (cur_rem == 0) ? cur.last : 1'b0;
                end
                check("start_data", spi_data_in, cur.d);
                check("start_dc", spi_dc_in, cur.dc);
                check("start_end", spi_end_txn, eend);
                inflight = 1'b1;
            end else begin
                check("spurious_start", spi_start, 1'b0);
            end
        end
        if (wv && pre != DEPTH && !fl) mq.push_back(e);
        if (fl) mq.delete();
        check("wr_ready", wr_ready, mq.size() != DEPTH);
        check("level", level, mq.size());
        mb2 = mb1;
        mb1 = mbusy;
    endtask

    task automatic push(input logic [7:0] d, input logic dc, input logic last, input logic [7:0] rep);
        wr_valid = 1'b1; wr_data = d; wr_dc = dc; wr_last = last; wr_rep = rep;
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (!(mq.size() == 0 && cur_rem == 0 && !inflight && !mbusy) && n < 300) begin
            tick();
            n++;
        end
        check({tag, "_timeout"}, n < 300, 1'b1);
        check({tag, "_idle"}, idle, 1'b1);
    endtask

    initial begin
        int s0, r0;
        #1 rstn = 1'b0;
        #11;
        check("rst_start", spi_start, 1'b0);
        check("rst_data_in", spi_data_in, 8'h00);
        check("rst_dc_in", spi_dc_in, 1'b0);
        check("rst_end_txn", spi_end_txn, 1'b1);
        check("rst_rd_data", rd_data, 8'h00);
        check("rst_rd_valid", rd_valid, 1'b0);
        check("rst_wr_ready", wr_ready, 1'b1);
        check("rst_idle", idle, 1'b1);
        check("rst_level", level, 0);
        @(negedge clk);
        rstn = 1'b1;

        // Two-byte command/data sequence, with push-to-start latency.
        s0 = n_start; r0 = n_rv;
        push(8'h2A, 1'b0, 1'b0, 8'd0);
        check("lat_e0", spi_start, 1'b0);
        push(8'h00, 1'b1, 1'b1, 8'd0);
        check("lat_e1", spi_start, 1'b1);
        tick();
        check("lat_e2", spi_start, 1'b0);
        drain("seq2");
        check("seq2_starts", n_start - s0, 2);
        check("seq2_rvalids", n_rv - r0, 2);

        // Fill past DEPTH while spi_ctrl reports busy.
        hold_busy = 1'b1;
        for (int i = 0; i < 5; i++) push(8'h10 + 8'(i), i[0], 1'b0, 8'd0);
        check("full_level", level, DEPTH);
        check("full_ready", wr_ready, 1'b0);
        check("full_idle", idle, 1'b0);
        hold_busy = 1'b0;
        s0 = n_start;
        drain("full");
        check("full_starts", n_start - s0, 4);

        // Known return byte.
        ret_a5 = 1'b1;
        push(8'h3C, 1'b1, 1'b1, 8'd0);
        drain("a5");
        check("a5_rd_data", rd_data, 8'hA5);
        ret_a5 = 1'b0;

        // Flush during the first byte's WAIT.
        dur_min = 6; dur_max = 6;
        r0 = n_rv;
        push(8'h01, 1'b0, 1'b0, 8'd0);
        push(8'h02, 1'b0, 1'b0, 8'd0);
        push(8'h03, 1'b0, 1'b1, 8'd0);
        s0 = n_start;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_level", level, 0);
        drain("flush");
        check("flush_starts", n_start - s0, 0);
        check("flush_rvalids", n_rv - r0, 1);

        // Asynchronous reset while a byte is in flight.
        push(8'h55, 1'b1, 1'b0, 8'd0);
        push(8'h66, 1'b1, 1'b0, 8'd0);
        tick();
        tick();
        check("rst_pre_busy", mbusy, 1'b1);
        @(posedge clk);
        #3 rstn = 1'b0;
        #1;
        check("arst_start", spi_start, 1'b0);
        check("arst_end_txn", spi_end_txn, 1'b1);
        check("arst_level", level, 0);
        check("arst_wr_ready", wr_ready, 1'b1);
        check("arst_rd_valid", rd_valid, 1'b0);
        mq.delete();
        cur_rem = 0;
        inflight = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        mb1 = mbusy; mb2 = mbusy;
        r0 = n_rv;
        for (int i = 0; i < 12; i++) tick();
        check("arst_no_rvalid", n_rv - r0, 0);
        drain("arst");
        dur_min = 1; dur_max = 3;

`ifdef SPI_SEQ_REPEAT_EN
        s0 = n_start; r0 = n_rv;
        push(8'hFF, 1'b1, 1'b1, 8'd3);
        drain("rep");
        check("rep_starts", n_start - s0, 4);
        check("rep_rvalids", n_rv - r0, 4);
`endif

        // Randomized traffic with occasional flushes.
        for (int i = 0; i < 600; i++) begin
            wr_valid = ($urandom % 2) == 0;
            wr_data  = 8'($urandom);
            wr_dc    = 1'($urandom);
            wr_last  = 1'($urandom);
            wr_rep   = 8'($urandom_range(2, 0));
            flush    = ($urandom % 40) == 0;
            tick();
        end
        wr_valid = 1'b0;
        flush = 1'b0;
        drain("rand");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
